// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode string constants and the pointer/count width helper.
package fifo_pkg;

  localparam int MODE_W = 40;
  localparam logic [MODE_W-1:0] MODE_TRUE  = 40'("TRUE");
  localparam logic [MODE_W-1:0] MODE_FALSE = 40'("FALSE");

  // Bits needed to represent 0..2**asize inclusive (always asize+1).
  function automatic int count_width(input int asize);
    return $clog2((1 << asize) + 1);
  endfunction

  // Anything other than "FALSE" selects first-word fall-through.
  function automatic bit is_fwft(input logic [MODE_W-1:0] mode);
    return mode != MODE_FALSE;
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Simple dual-port storage: one write port, one read port with selectable
// combinational (fall-through) or registered read data.
module sync_ram
  import fifo_pkg::*;
#(
  parameter int                 DSIZE       = 8,
  parameter int                 ASIZE       = 4,
  parameter logic [MODE_W-1:0]  FALLTHROUGH = MODE_TRUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int  DEPTH = 1 << ASIZE;
  localparam bit  FWFT  = is_fwft(FALLTHROUGH);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] rdata_d, rdata_q;

  // NOTE: the storage array has no reset on purpose; clearing it would force
  // flops instead of RAM, and the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // The registered path is simply unused (and pruned) in fall-through mode.
  assign rdata = FWFT ? mem_q[raddr] : rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: extended-pointer full/empty detection, occupancy count,
// threshold flags and sticky overflow/underflow; storage lives in sync_ram.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int                 DSIZE       = 8,
  parameter int                 ASIZE       = 4,
  parameter logic [MODE_W-1:0]  FALLTHROUGH = MODE_TRUE,
  parameter int                 AFULL_TH    = (1 << ASIZE) - 2,
  parameter int                 AEMPTY_TH   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wen,
  input  logic [DSIZE-1:0]               wdata,
  input  logic                           ren,
  output logic [DSIZE-1:0]               rdata,
  output logic                           wfull,
  output logic                           rempty,
  output logic                           afull,
  output logic                           aempty,
  output logic [count_width(ASIZE)-1:0]  count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = count_width(ASIZE);

  logic [PW-1:0] wptr_d, wptr_q;
  logic [PW-1:0] rptr_d, rptr_q;
  logic          ovf_d, ovf_q;
  logic          unf_d, unf_q;
  logic          w_acc, r_acc;

  // Flags depend only on registered pointers, never on this cycle's requests.
  assign wfull  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                  (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign rempty = (wptr_q == rptr_q);
  assign count  = wptr_q - rptr_q;
  assign afull  = (int'(count) >= AFULL_TH);
  assign aempty = (int'(count) <= AEMPTY_TH);

  assign w_acc = wen && !wfull;
  assign r_acc = ren && !rempty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (w_acc) wptr_d = wptr_q + 1'b1;
    if (r_acc) rptr_d = rptr_q + 1'b1;
    if (wen && wfull)  ovf_d = 1'b1;
    if (ren && rempty) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  sync_ram #(
    .DSIZE       (DSIZE),
    .ASIZE       (ASIZE),
    .FALLTHROUGH (FALLTHROUGH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_acc),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .re    (r_acc),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a fall-through and a registered-read FIFO share one
// stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, wen, ren;
  logic [7:0] wdata;

  logic [7:0] f_rdata, r_rdata;
  logic       f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
  logic       r_wfull, r_rempty, r_afull, r_aempty, r_ovf, r_unf;
  logic [4:0] f_count, r_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  logic [7:0] exp_reg;
  logic       m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE")) u_fwft (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .afull(f_afull),
    .aempty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE")) u_reg (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(r_rdata), .wfull(r_wfull), .rempty(r_rempty), .afull(r_afull),
    .aempty(r_aempty), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  // One clock of stimulus; the reference model advances on the same edge.
  task automatic step(input logic r_st, input logic w, input logic [7:0] wd,
                      input logic r);
    bit w_acc, r_acc;
    rst = r_st; wen = w; wdata = wd; ren = r;
    @(posedge clk);
    if (r_st) begin
      sb.delete();
      m_ovf = 1'b0; m_unf = 1'b0; exp_reg = 8'h00;
    end else begin
      w_acc = w && (sb.size() < 16);
      r_acc = r && (sb.size() > 0);
      if (w && !w_acc) m_ovf = 1'b1;
      if (r && !r_acc) m_unf = 1'b1;
      if (r_acc) exp_reg = sb.pop_front();
      if (w_acc) sb.push_back(wd);
    end
    #1;
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (f_count !== 5'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", f_count); end
    total++; if (f_rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%b exp=1", f_rempty); end
    total++; if (f_wfull !== 1'b0)  begin bad++; $display("FAIL reset_wfull got=%b exp=0", f_wfull); end
    total++; if (f_aempty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", f_aempty); end
    total++; if (f_afull !== 1'b0)  begin bad++; $display("FAIL reset_afull got=%b exp=0", f_afull); end
    total++; if ({f_ovf, f_unf, r_ovf, r_unf} !== 4'b0000)
      begin bad++; $display("FAIL reset_sticky got=%b exp=0000", {f_ovf, f_unf, r_ovf, r_unf}); end
    total++; if (r_rdata !== 8'h00) begin bad++; $display("FAIL reset_reg_rdata got=%h exp=00", r_rdata); end
  endtask

  task automatic test_fill();
    logic e_afull, e_wfull, e_aempty;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      e_afull  = (i + 1 >= 14);
      e_wfull  = (i + 1 == 16);
      e_aempty = (i + 1 <= 2);
      total++; if (f_count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, f_count, i + 1); end
      total++; if (f_afull !== e_afull)   begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, f_afull, e_afull); end
      total++; if (f_wfull !== e_wfull)   begin bad++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, f_wfull, e_wfull); end
      total++; if (f_aempty !== e_aempty) begin bad++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, f_aempty, e_aempty); end
      total++; if (f_ovf !== 1'b0)        begin bad++; $display("FAIL fill_ovf[%0d] got=%b exp=0", i, f_ovf); end
    end
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    total++; if (f_ovf !== 1'b1 || r_ovf !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b%b exp=11", f_ovf, r_ovf); end
    total++; if (f_count !== 5'd16) begin bad++; $display("FAIL overflow_count got=%0d exp=16", f_count); end
    total++; if (f_rdata !== 8'h00) begin bad++; $display("FAIL overflow_head got=%h exp=00", f_rdata); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      total++; if (f_rdata !== sb[0] || f_rdata !== 8'(i))
        begin bad++; $display("FAIL drain_fwft[%0d] got=%h exp=%h", i, f_rdata, 8'(i)); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      total++; if (r_rdata !== exp_reg) begin bad++; $display("FAIL drain_reg[%0d] got=%h exp=%h", i, r_rdata, exp_reg); end
      total++; if (r_count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, r_count, 15 - i); end
    end
    total++; if (f_rempty !== 1'b1 || r_rempty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b%b exp=11", f_rempty, r_rempty); end
    total++; if (f_unf !== 1'b0) begin bad++; $display("FAIL drain_unf_early got=%b exp=0", f_unf); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    total++; if (f_unf !== 1'b1 || r_unf !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b%b exp=11", f_unf, r_unf); end
    total++; if (f_count !== 5'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", f_count); end
    total++; if (r_rdata !== 8'h0F) begin bad++; $display("FAIL underflow_reg_hold got=%h exp=0f", r_rdata); end
  endtask

  task automatic test_fwft();
    reset_dut();
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    total++; if (f_rdata !== 8'hA5) begin bad++; $display("FAIL fwft_data got=%h exp=a5", f_rdata); end
    total++; if (f_rempty !== 1'b0) begin bad++; $display("FAIL fwft_rempty got=%b exp=0", f_rempty); end
    total++; if (r_rdata !== 8'h00) begin bad++; $display("FAIL fwft_reg_idle got=%h exp=00", r_rdata); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    total++; if (f_rdata !== 8'hA5) begin bad++; $display("FAIL fwft_hold got=%h exp=a5", f_rdata); end
  endtask

  task automatic test_registered();
    reset_dut();
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    total++; if (r_rdata !== 8'h00) begin bad++; $display("FAIL reg_before_read got=%h exp=00", r_rdata); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    total++; if (r_rdata !== 8'h11) begin bad++; $display("FAIL reg_first got=%h exp=11", r_rdata); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      total++; if (r_rdata !== 8'h11) begin bad++; $display("FAIL reg_hold[%0d] got=%h exp=11", i, r_rdata); end
    end
    total++; if (r_count !== 5'd1) begin bad++; $display("FAIL reg_count got=%0d exp=1", r_count); end
    total++; if (f_rdata !== 8'h22) begin bad++; $display("FAIL reg_fwft_head got=%h exp=22", f_rdata); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      total++; if (f_rdata !== sb[0]) begin bad++; $display("FAIL b2b_fwft[%0d] got=%h exp=%h", i, f_rdata, sb[0]); end
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      total++; if (f_count !== 5'd8 || r_count !== 5'd8)
        begin bad++; $display("FAIL b2b_count[%0d] got=%0d/%0d exp=8", i, f_count, r_count); end
      total++; if (r_rdata !== exp_reg) begin bad++; $display("FAIL b2b_reg[%0d] got=%h exp=%h", i, r_rdata, exp_reg); end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    total++; if (f_wfull !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", f_wfull); end
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    total++; if (f_count !== 5'd15) begin bad++; $display("FAIL full_rw_count got=%0d exp=15", f_count); end
    total++; if (f_ovf !== 1'b1)    begin bad++; $display("FAIL full_rw_ovf got=%b exp=1", f_ovf); end
    total++; if (r_rdata !== exp_reg) begin bad++; $display("FAIL full_rw_reg got=%h exp=%h", r_rdata, exp_reg); end
    for (int i = 0; i < 15; i++) begin
      total++; if (f_rdata !== sb[0]) begin bad++; $display("FAIL full_rw_order[%0d] got=%h exp=%h", i, f_rdata, sb[0]); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    total++; if (f_count !== 5'd9 || f_unf !== 1'b1)
      begin bad++; $display("FAIL mid_pre got=%0d/%b exp=9/1", f_count, f_unf); end
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    total++; if (f_count !== 5'd0 || r_count !== 5'd0)
      begin bad++; $display("FAIL mid_count got=%0d/%0d exp=0", f_count, r_count); end
    total++; if (f_rempty !== 1'b1) begin bad++; $display("FAIL mid_rempty got=%b exp=1", f_rempty); end
    total++; if ({f_ovf, f_unf} !== 2'b00) begin bad++; $display("FAIL mid_sticky got=%b exp=00", {f_ovf, f_unf}); end
    total++; if (r_rdata !== 8'h00) begin bad++; $display("FAIL mid_reg_rdata got=%h exp=00", r_rdata); end
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    exp_reg = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_registered();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address bits; DEPTH = 2**ASIZE words.
REQ-003 SHALL have parameter FALLTHROUGH, default "TRUE", first-word fall-through read mode; "FALSE" selects registered read.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in words.
REQ-005 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in words.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wen  input  1  write request.
REQ-010 wdata  input  DSIZE  write data.
REQ-011 ren  input  1  read request (pop).
REQ-012 rdata  output  DSIZE  read data.
REQ-013 wfull  output  1  FIFO holds DEPTH words.
REQ-014 rempty  output  1  FIFO holds 0 words.
REQ-015 afull  output  1  count >= AFULL_TH.
REQ-016 aempty  output  1  count <= AEMPTY_TH.
REQ-017 count  output  ASIZE+1  words held, range 0..DEPTH.
REQ-018 overflow  output  1  sticky: write attempted while wfull.
REQ-019 underflow  output  1  sticky: read attempted while rempty.

Function
REQ-020 Write accepted iff wen && !wfull; accepted word stored at wptr, wptr increments modulo DEPTH.
REQ-021 Read accepted iff ren && !rempty; rptr increments modulo DEPTH.
REQ-022 Pointers ASIZE+1 bits; wfull = (ptr MSBs differ, low ASIZE bits equal); rempty = (pointers equal).
REQ-023 count = wptr - rptr modulo 2**(ASIZE+1); updates same edge as accepted operations; accepted simultaneous write and read leaves count unchanged.
REQ-024 wen while wfull SHALL be ignored even if a read is accepted that cycle; overflow set next cycle.
REQ-025 ren while rempty SHALL be ignored even if a write is accepted that cycle; underflow set next cycle.
REQ-026 overflow and underflow remain set until rst.
REQ-027 FALLTHROUGH="TRUE": rdata = mem[rptr] combinationally; valid whenever rempty=0; word written into empty FIFO visible one cycle after the write edge, when rempty falls.
REQ-028 FALLTHROUGH="FALSE": rdata registered; on an accepted read, rdata takes mem[rptr] at that edge (1-cycle latency); otherwise rdata holds.
REQ-029 wfull, rempty, afull, aempty are functions of registered pointers only, never of wen/ren in the same cycle.
REQ-030 Pointer wrap from DEPTH-1 to 0 SHALL not disturb data or flags.

Reset
REQ-031 rst SHALL clear wptr, rptr, overflow, underflow; after reset count=0, rempty=1, wfull=0, aempty=1, afull=0.
REQ-032 Registered rdata SHALL reset to 0; fall-through rdata unconstrained while rempty=1.
REQ-033 rst mid-operation SHALL win over simultaneous wen/ren; memory contents need not be cleared.

Structure
REQ-034 Shared package fifo_pkg SHALL hold the mode string constants and the count-width function clog2-based helper.
REQ-035 Storage SHALL be sub-module sync_ram (one write port, one read port, FALLTHROUGH-selectable read); pointer/flag logic in sync_fifo.

Verification (DSIZE=8, ASIZE=4, DEPTH=16)
REQ-036 Reset, then write 0x00..0x0F -> wfull=1, count=16, afull asserted at count=14; 17th write -> overflow=1, data unchanged.
REQ-037 Drain full FIFO -> reads return 0x00..0x0F in order; rempty=1 after 16th pop; one more ren -> underflow=1.
REQ-038 FWFT: write 0xA5 to empty FIFO -> rdata=0xA5 and rempty=0 next cycle, without ren.
REQ-039 Registered mode: FIFO holds 0x11,0x22; ren one cycle -> rdata=0x11 after that edge; hold ren low -> rdata stays 0x11.
REQ-040 Steady simultaneous wen/ren at count=8 for 40 cycles (pointer wrap) -> count stays 8, data order preserved; wen+ren at full -> only read accepted, count=15, overflow=1.
REQ-041 rst asserted with count=9 and wen=ren=1 -> next cycle count=0, rempty=1, overflow=underflow=0.
